cam_plane_store: RTL and testbench

Parametrised successor to the camera-FIFO-to-SDRAM store controller. Drains RGB565 pixels from the camera FIFO and writes them to SDRAM as separate feature planes, for the MobileNet input stage. Two modes:
- planar RGB: three planes.
- grayscale: one plane.

It adds a programmable base address, an explicit end-of-frame on an empty FIFO, abort, a pixel-count limit and a write-acknowledge timeout.

---
 rtl/cam_store_pkg.sv | 34 +++
 rtl/cam_pixel_map.sv | 45 ++++
 rtl/cam_plane_store.sv | 189 ++++++++++++++++++
 tb/tb_cam_plane_store.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_store_pkg.sv
// Shared types and constants for the camera-to-SDRAM plane store.
// RGB565 field positions and per-mode channel counts live here.
package cam_store_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_SUSPEND,
        ST_RD0,
        ST_RD1,
        ST_WRITE,
        ST_WAIT,
        ST_NEXT,
        ST_FINISH
    } state_t;

    localparam logic MODE_RGB  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    localparam logic [1:0] NCH_RGB  = 2'd3;
    localparam logic [1:0] NCH_GRAY = 2'd1;

    function automatic logic [1:0] num_channels(input logic mode);
        return (mode == MODE_GRAY) ? NCH_GRAY : NCH_RGB;
    endfunction

endpackage

// File: rtl/cam_pixel_map.sv
// Combinational RGB565 -> per-plane channel value, zero-extended to DATA_W.
// Planar mode emits one 6-bit field per channel; grayscale emits the averaged Y.
module cam_pixel_map
    import cam_store_pkg::*;
#(
    parameter int PIX_W  = 16,
    parameter int DATA_W = 16
) (
    input  logic [PIX_W-1:0]  pixel,
    input  logic [1:0]        ch,
    input  logic              mode,
    output logic [DATA_W-1:0] data
);

    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic [7:0] sum;
    logic [5:0] gray;
    logic [5:0] val;

    assign r = pixel[R_HI:R_LO];
    assign g = pixel[G_HI:G_LO];
    assign b = pixel[B_HI:B_LO];

    // All three terms are left-aligned to 6/7 bits; the total never exceeds 250.
    assign sum  = {2'b00, r, 1'b0} + {1'b0, g, 1'b0} + {2'b00, b, 1'b0};
    assign gray = 6'(sum >> 2);

    always_comb begin
        val = '0;
        if (mode == MODE_GRAY) begin
            val = gray;
        end else begin
            case (ch)
                2'd0:    val = {r, 1'b0};
                2'd1:    val = g;
                2'd2:    val = {b, 1'b0};
                default: val = '0;
            endcase
        end
        data = DATA_W'(val);
    end

endmodule

// File: rtl/cam_plane_store.sv
// Drains RGB565 pixels from the camera FIFO into SDRAM as separate feature planes.
// One pixel at a time: read, then one write/ack handshake per plane.
module cam_plane_store
    import cam_store_pkg::*;
#(
    parameter int PIX_W        = 16,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 19,
    parameter int CNT_W        = 10,
    parameter int PLANE_STRIDE = 4096,
    parameter int READ_THRESH  = 16,
    parameter int MAX_PIXELS   = 4096,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_baseAddr,
    input  logic              i_abort,
    input  logic              i_process,
    input  logic              i_complete,
    input  logic [CNT_W-1:0]  i_remainOnFifo,
    input  logic [PIX_W-1:0]  i_dataFifo,
    input  logic              i_sdramReady,
    output logic              o_get,
    output logic              o_enReadFifo,
    output logic              o_rdClkFifo,
    output logic [DATA_W-1:0] o_dataSdram,
    output logic [ADDR_W-1:0] o_addressToSdram,
    output logic              o_wrSdram,
    output logic              o_busy,
    output logic              o_finish,
    output logic              o_error,
    output logic [ADDR_W-1:0] o_pixelCount
);

    localparam int CW = ADDR_W + 1;
    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    state_t            state, state_d;
    logic              mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [PIX_W-1:0]  pix_q;
    logic [1:0]        ch_q;
    logic [TW-1:0]     wait_cnt;
    logic              abort_q;
    logic              err_q;
    logic              set_err;

    logic [CW-1:0]     cnt_inc;
    logic              last_ch;
    logic              fifo_empty;
    logic              timeout;

    assign cnt_inc    = {1'b0, count_q} + CW'(1);
    assign last_ch    = (ch_q == num_channels(mode_q) - 2'd1);
    assign fifo_empty = (i_remainOnFifo == '0);
    assign timeout    = (wait_cnt == TW'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d      = state;
        o_get        = 1'b0;
        o_enReadFifo = 1'b0;
        o_rdClkFifo  = 1'b0;
        o_wrSdram    = 1'b0;
        o_finish     = 1'b0;
        set_err      = 1'b0;
        case (state)
            ST_IDLE: if (i_start) state_d = ST_START;
            ST_START: begin
                o_get = 1'b1;
                if (abort_q) begin
                    set_err = 1'b1;
                    state_d = ST_FINISH;
                end else if (i_process) begin
                    state_d = ST_SUSPEND;
                end
            end
            ST_SUSPEND: begin
                o_enReadFifo = 1'b1;
                if (abort_q) begin
                    set_err = 1'b1;
                    state_d = ST_FINISH;
                end else if (i_remainOnFifo > CNT_W'(READ_THRESH) || (i_complete && !fifo_empty)) begin
                    state_d = ST_RD0;
                end else if (i_complete) begin
                    state_d = ST_FINISH;
                end
            end
            ST_RD0: begin
                o_enReadFifo = 1'b1;
                o_rdClkFifo  = 1'b1;
                state_d      = ST_RD1;
            end
            ST_RD1: begin
                o_enReadFifo = 1'b1;
                state_d      = ST_WRITE;
            end
            ST_WRITE: begin
                o_wrSdram = 1'b1;
                state_d   = ST_WAIT;
            end
            // Abort is deliberately not looked at here: the handshake must finish.
            ST_WAIT: begin
                if (i_sdramReady) begin
                    state_d = last_ch ? ST_NEXT : ST_WRITE;
                end else if (timeout) begin
                    set_err = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_NEXT: begin
                if (abort_q) begin
                    set_err = 1'b1;
                    state_d = ST_FINISH;
                end else if (cnt_inc == CW'(MAX_PIXELS) || (i_complete && fifo_empty)) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_SUSPEND;
                end
            end
            ST_FINISH: begin
                o_finish = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_RGB;
            base_q   <= '0;
            count_q  <= '0;
            pix_q    <= '0;
            ch_q     <= '0;
            wait_cnt <= '0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                ST_IDLE: if (i_start) begin
                    mode_q  <= i_mode;
                    base_q  <= i_baseAddr;
                    count_q <= '0;
                    err_q   <= 1'b0;
                    abort_q <= 1'b0;
                end
                ST_RD1: begin
                    pix_q <= i_dataFifo;
                    ch_q  <= '0;
                end
                ST_WRITE: wait_cnt <= '0;
                ST_WAIT: begin
                    if (i_sdramReady) begin
                        if (!last_ch) ch_q <= ch_q + 2'd1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                ST_NEXT: count_q <= cnt_inc[ADDR_W-1:0];
                default: ;
            endcase
            if (set_err) err_q <= 1'b1;
            if (state != ST_IDLE && i_abort) abort_q <= 1'b1;
        end
    end

    cam_pixel_map #(
        .PIX_W (PIX_W),
        .DATA_W(DATA_W)
    ) u_map (
        .pixel(pix_q),
        .ch   (ch_q),
        .mode (mode_q),
        .data (o_dataSdram)
    );

    // Address and data are pure functions of held registers, so they stay stable through WAIT.
    assign o_addressToSdram = base_q + (ADDR_W'(ch_q) * ADDR_W'(PLANE_STRIDE)) + count_q;
    assign o_busy           = (state != ST_IDLE);
    assign o_error          = err_q;
    assign o_pixelCount     = count_q;

endmodule

// File: tb/tb_cam_plane_store.sv
// Directed bench for cam_plane_store: planar/gray frames, empty-FIFO end,
// ack timeout, abort during a handshake and reset mid-write.
module tb_cam_plane_store;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_mode = 1'b0;
    logic [18:0] i_baseAddr = '0;
    logic        i_abort = 1'b0;
    logic        i_process = 1'b0;
    logic        i_complete = 1'b0;
    logic [9:0]  i_remainOnFifo = '0;
    logic [15:0] i_dataFifo = '0;
    logic        i_sdramReady = 1'b1;
    logic        o_get, o_enReadFifo, o_rdClkFifo, o_wrSdram, o_busy, o_finish, o_error;
    logic [15:0] o_dataSdram;
    logic [18:0] o_addressToSdram, o_pixelCount;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    logic [15:0] fifo_q[$];
    logic [18:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_t[$];

    int exp_a[9] = '{0, 4096, 8192, 1, 4097, 8193, 2, 4098, 8194};
    int exp_d[9] = '{'h3E, 0, 0, 0, 'h3F, 0, 0, 0, 'h3E};

    cam_plane_store dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_mode          (i_mode),
        .i_baseAddr      (i_baseAddr),
        .i_abort         (i_abort),
        .i_process       (i_process),
        .i_complete      (i_complete),
        .i_remainOnFifo  (i_remainOnFifo),
        .i_dataFifo      (i_dataFifo),
        .i_sdramReady    (i_sdramReady),
        .o_get           (o_get),
        .o_enReadFifo    (o_enReadFifo),
        .o_rdClkFifo     (o_rdClkFifo),
        .o_dataSdram     (o_dataSdram),
        .o_addressToSdram(o_addressToSdram),
        .o_wrSdram       (o_wrSdram),
        .o_busy          (o_busy),
        .o_finish        (o_finish),
        .o_error         (o_error),
        .o_pixelCount    (o_pixelCount)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    // FIFO model: a read strobe pops the head onto the data bus.
    always @(negedge i_clk) begin
        if (o_rdClkFifo) begin
            rd_cnt++;
            if (fifo_q.size() > 0) i_dataFifo = fifo_q.pop_front();
        end
        i_remainOnFifo = 10'(fifo_q.size());
    end

    always @(negedge i_clk) begin
        if (o_wrSdram) begin
            wr_addr.push_back(o_addressToSdram);
            wr_data.push_back(o_dataSdram);
            wr_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic mode, input logic [18:0] base);
        @(negedge i_clk);
        i_start = 1'b1; i_mode = mode; i_baseAddr = base;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_finish(input int maxc, input string tag);
        int n = 0;
        while (!o_finish && n < maxc) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, 32'(o_finish), 32'd1);
    endtask

    task automatic wait_wr(input int maxc, input string tag);
        int n = 0;
        while (!o_wrSdram && n < maxc) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, 32'(o_wrSdram), 32'd1);
    endtask

    task automatic end_frame();
        i_process = 1'b0; i_complete = 1'b0;
        @(negedge i_clk);
        check("finish_pulse_1cyc", 32'(o_finish), 32'd0);
        check("idle_after_finish", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int b, rd0;
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_wr", 32'(o_wrSdram), 32'd0);
        check("rst_err", 32'(o_error), 32'd0);
        check("rst_cnt", 32'(o_pixelCount), 32'd0);
        check("rst_addr", 32'(o_addressToSdram), 32'd0);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;

        // planar frame of three primaries
        fifo_q.push_back(16'hF800); fifo_q.push_back(16'h07E0); fifo_q.push_back(16'h001F);
        b = wr_addr.size();
        start_frame(1'b0, 19'd0);
        check("t1_get", 32'(o_get), 32'd1);
        check("t1_busy", 32'(o_busy), 32'd1);
        i_process = 1'b1; i_complete = 1'b1;
        wait_finish(200, "t1_finish");
        check("t1_count", 32'(o_pixelCount), 32'd3);
        check("t1_nwr", 32'(wr_addr.size() - b), 32'd9);
        if (wr_addr.size() >= b + 9) begin
            for (int i = 0; i < 9; i++) begin
                check("t1_addr", 32'(wr_addr[b+i]), 32'(exp_a[i]));
                check("t1_data", 32'(wr_data[b+i]), 32'(exp_d[i]));
            end
            check("t1_pix_period", 32'(wr_t[b+3] - wr_t[b]), 32'd10);
        end
        end_frame();

        // grayscale, base 100
        fifo_q.push_back(16'hFFFF); fifo_q.push_back(16'h0841);
        b = wr_addr.size();
        start_frame(1'b1, 19'd100);
        i_process = 1'b1; i_complete = 1'b1;
        wait_finish(100, "t2_finish");
        check("t2_count", 32'(o_pixelCount), 32'd2);
        check("t2_nwr", 32'(wr_addr.size() - b), 32'd2);
        if (wr_addr.size() >= b + 2) begin
            check("t2_addr0", 32'(wr_addr[b]), 32'd100);
            check("t2_data0", 32'(wr_data[b]), 32'h3E);
            check("t2_addr1", 32'(wr_addr[b+1]), 32'd101);
            check("t2_data1", 32'(wr_data[b+1]), 32'h02);
            check("t2_pix_period", 32'(wr_t[b+1] - wr_t[b]), 32'd6);
        end
        end_frame();

        // end of frame on an empty FIFO
        b = wr_addr.size(); rd0 = rd_cnt;
        start_frame(1'b0, 19'd0);
        i_process = 1'b1;
        repeat (4) @(negedge i_clk);
        check("t3_suspend_rd", 32'(o_enReadFifo), 32'd1);
        i_complete = 1'b1;
        wait_finish(20, "t3_finish");
        check("t3_count", 32'(o_pixelCount), 32'd0);
        check("t3_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("t3_no_wr", 32'(wr_addr.size() - b), 32'd0);
        end_frame();

        // acknowledge timeout
        fifo_q.push_back(16'hFFFF);
        i_sdramReady = 1'b0;
        start_frame(1'b1, 19'd0);
        i_process = 1'b1; i_complete = 1'b1;
        wait_wr(50, "t4_wr");
        @(posedge i_clk);
        repeat (254) @(posedge i_clk);
        #1;
        check("t4_err_254", 32'(o_error), 32'd0);
        check("t4_fin_254", 32'(o_finish), 32'd0);
        @(posedge i_clk);
        #1;
        check("t4_err_255", 32'(o_error), 32'd1);
        check("t4_fin_255", 32'(o_finish), 32'd1);
        check("t4_count", 32'(o_pixelCount), 32'd0);
        @(negedge i_clk);
        i_sdramReady = 1'b1;
        end_frame();

        // abort during WAIT completes the handshake first
        fifo_q.push_back(16'h0841); fifo_q.push_back(16'hFFFF);
        i_sdramReady = 1'b0;
        b = wr_addr.size();
        start_frame(1'b1, 19'd0);
        check("t5_err_clr", 32'(o_error), 32'd0);
        i_process = 1'b1; i_complete = 1'b1;
        wait_wr(50, "t5_wr");
        @(posedge i_clk); #1;
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("t5_still_wait", 32'(o_busy), 32'd1);
        check("t5_no_err_yet", 32'(o_error), 32'd0);
        i_sdramReady = 1'b1;
        wait_finish(20, "t5_finish");
        check("t5_err", 32'(o_error), 32'd1);
        check("t5_count", 32'(o_pixelCount), 32'd1);
        check("t5_nwr", 32'(wr_addr.size() - b), 32'd1);
        end_frame();

        // next start clears the error and drains the leftover pixel
        b = wr_addr.size();
        start_frame(1'b1, 19'd200);
        check("t5b_err_clr", 32'(o_error), 32'd0);
        i_process = 1'b1; i_complete = 1'b1;
        wait_finish(50, "t5b_finish");
        check("t5b_count", 32'(o_pixelCount), 32'd1);
        check("t5b_nwr", 32'(wr_addr.size() - b), 32'd1);
        if (wr_addr.size() > b) begin
            check("t5b_addr", 32'(wr_addr[b]), 32'd200);
            check("t5b_data", 32'(wr_data[b]), 32'h3E);
        end
        end_frame();

        // reset in the middle of a handshake
        fifo_q.push_back(16'hFFFF);
        i_sdramReady = 1'b0;
        start_frame(1'b1, 19'd300);
        i_process = 1'b1; i_complete = 1'b1;
        wait_wr(50, "t6_wr");
        @(posedge i_clk); #1;
        check("t6_addr_pre", 32'(o_addressToSdram), 32'd300);
        i_reset = 1'b0;
        #1;
        check("t6_busy", 32'(o_busy), 32'd0);
        check("t6_wr", 32'(o_wrSdram), 32'd0);
        check("t6_addr", 32'(o_addressToSdram), 32'd0);
        check("t6_data", 32'(o_dataSdram), 32'd0);
        check("t6_en", 32'(o_enReadFifo), 32'd0);
        check("t6_cnt", 32'(o_pixelCount), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1; i_process = 1'b0; i_complete = 1'b0; i_sdramReady = 1'b1;
        fifo_q.push_back(16'h0841);
        b = wr_addr.size();
        start_frame(1'b1, 19'd300);
        i_process = 1'b1; i_complete = 1'b1;
        wait_finish(50, "t6_finish");
        check("t6_count", 32'(o_pixelCount), 32'd1);
        if (wr_addr.size() > b) begin
            check("t6_raddr", 32'(wr_addr[b]), 32'd300);
            check("t6_rdata", 32'(wr_data[b]), 32'h02);
        end else begin
            check("t6_nwr", 32'(wr_addr.size() - b), 32'd1);
        end
        end_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
